truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
- Synchronous stimulus controller for small combinational gate blocks (and2-class, N_IN inputs, 1 output).
- Walks every input combination 0 .. 2^N_IN-1 in ascending order and holds each for a programmable settle time.
- Samples the gate output, compares it against a supplied expected truth table, and reports pass/fail, mismatch count and the first failing index.
- Sits between lab/top-level control (start/abort) and the gate under exercise, replacing free-running delay-based stimulus.

Parameters:
- N_IN, 2, number of gate inputs; legal 1..8.
- HOLD_CYCLES, 3, clock cycles each combination is held before sampling; legal >=1 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; accepted in IDLE or DONE only
- abort  input  1  synchronous abort; returns to IDLE
- dut_out  input  1  output of the gate being exercised
- exp_table  input  2**N_IN  expected output; bit k = expected dut_out for stim==k
- stim  output  N_IN  input vector driven to the gate
- busy  output  1  high in SETTLE/SAMPLE
- done  output  1  high in DONE
- pass  output  1  done && err_count==0
- sample_valid  output  1  one-cycle pulse per sampled combination
- sample_idx  output  N_IN  combination index of the current sample
- sample_val  output  1  dut_out value captured at that sample
- err_count  output  N_IN+1  number of mismatches in the current/last sweep
- err_idx  output  N_IN  index of the first mismatch; 0 if none

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - stim, sample_idx, err_idx, err_count = 0; busy, done, pass, sample_valid, sample_val = 0.
  - The internal err_seen flag and the settle counter are cleared.
  - Reset mid-sweep aborts immediately, with no partial result retained.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: stim = 0. When start=1: idx=0, stim=0, cnt=HOLD_CYCLES-1, err_count=0, err_idx=0, err_seen=0; go to SETTLE.
- SETTLE: stim holds idx. If cnt==0 go to SAMPLE, else cnt decrements.
- SAMPLE (one cycle, output registered on exit):
  - sample_val = dut_out, sample_idx = idx, sample_valid = 1 for the following cycle.
  - If dut_out != exp_table[idx]: err_count increments; if err_seen==0, err_idx = idx and err_seen = 1.
  - If idx == 2^N_IN-1, go to DONE.
  - Otherwise idx and stim increment, cnt = HOLD_CYCLES-1, go to SETTLE.
- Timing: each combination costs HOLD_CYCLES+1 cycles. done rises 2^N_IN*(HOLD_CYCLES+1) cycles after the start-accept edge.
- DONE:
  - done=1, pass valid; stim holds its last value; results hold until restart or reset.
  - start restarts exactly as from IDLE: results clear on the accept edge.
- start while busy is ignored.
- abort (any state except IDLE) goes to IDLE:
  - stim=0, done=0, pass=0.
  - err_count/err_idx keep their partial values until the next start.
  - abort has priority over start in the same cycle.
- dut_out is sampled only in SAMPLE; glitches during SETTLE are ignored by design.
- Counters never wrap: err_count max = 2^N_IN fits in N_IN+1 bits. The idx increment is suppressed at the final index.

Optional Feature:
- Macro: TT_CAPTURE_EN.
- When defined:
  - Extra output obs_table [2**N_IN-1:0].
  - Bit sample_idx is written with sample_val at every sample.
  - Cleared to 0 on reset and on start-accept; holds through DONE and abort.
- When undefined: no port, no storage; all other behaviour is identical.

Test Plan:
- N_IN=2, HOLD_CYCLES=3, exp_table=4'b1000, correct AND gate on dut_out, single start pulse:
  - stim steps 0,1,2,3 every 4 cycles; four sample_valid pulses with sample_val 0,0,0,1.
  - done rises 16 cycles after accept; pass=1, err_count=0, err_idx=0.
  - With TT_CAPTURE_EN: obs_table=4'b1000.
- dut_out driven by an OR gate, exp_table=4'b1000 -> err_count=2, err_idx=1, pass=0 (obs_table=4'b1110 if enabled).
- dut_out tied 0, exp_table=4'b1000 -> err_count=1, err_idx=3, pass=0.
- start pulsed again at stim=2 mid-sweep -> ignored, sweep completes normally. Then start in DONE -> done falls next cycle, err_count cleared, new sweep identical to the first.
- abort asserted in the 2nd SETTLE cycle of idx=1 -> IDLE next cycle, stim=0, busy=0, done=0. abort+start in the same cycle -> IDLE wins.
- rst_n pulled low asynchronously mid-SETTLE (between clock edges) -> all outputs 0 immediately. After release, no activity until start.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps every input combination of a small gate block
// in ascending order. Each combination is held for HOLD_CYCLES cycles, then the
// gate output is sampled and compared against exp_table.
// Reports pass/fail, the mismatch count and the index of the first mismatch.
// Optional feature macro: TT_CAPTURE_EN adds the obs_table output, which
// holds every sampled gate output.
module truth_table_sequencer #(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned HOLD_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 dut_out,
    input  logic [2**N_IN-1:0]   exp_table,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 sample_valid,
    output logic [N_IN-1:0]      sample_idx,
    output logic                 sample_val,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      err_idx
`ifdef TT_CAPTURE_EN
    ,
    output logic [2**N_IN-1:0]   obs_table
`endif
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0]  IDX_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0]  IDX_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]    ERR_ONE  = (N_IN + 1)'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Reject illegal configurations at elaboration time.
    if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
        $error("truth_table_sequencer: N_IN must be in 1..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("truth_table_sequencer: HOLD_CYCLES must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN:0]    err_count_q, err_count_d;
    logic [N_IN-1:0]  err_idx_q, err_idx_d;
    logic             err_seen_q, err_seen_d;
    logic             sample_valid_q, sample_valid_d;
    logic [N_IN-1:0]  sample_idx_q, sample_idx_d;
    logic             sample_val_q, sample_val_d;

    logic do_abort;
    logic accept;
    logic do_sample;
    logic mismatch;

    // Abort applies outside IDLE only, but it always blocks a same-cycle start.
    always_comb begin
        do_abort  = abort && (state_q != ST_IDLE);
        accept    = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        do_sample = !do_abort && (state_q == ST_SAMPLE);
        mismatch  = dut_out != exp_table[idx_q];
    end

    // Next-state and result-update logic.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        err_count_d    = err_count_q;
        err_idx_d      = err_idx_q;
        err_seen_d     = err_seen_q;
        sample_valid_d = 1'b0;
        sample_idx_d   = sample_idx_q;
        sample_val_d   = sample_val_q;

        if (do_abort) begin
            // Partial error results stay visible until the next start.
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            state_d     = ST_SETTLE;
            idx_d       = '0;
            cnt_d       = CNT_LOAD;
            err_count_d = '0;
            err_idx_d   = '0;
            err_seen_d  = 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_SAMPLE: begin
                    sample_valid_d = 1'b1;
                    sample_idx_d   = idx_q;
                    sample_val_d   = dut_out;
                    if (mismatch) begin
                        err_count_d = err_count_q + ERR_ONE;
                        if (!err_seen_q) begin
                            err_idx_d  = idx_q;
                            err_seen_d = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        // Index stays at the last combination; it never wraps.
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_SETTLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            err_count_q    <= '0;
            err_idx_q      <= '0;
            err_seen_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            sample_val_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            err_count_q    <= err_count_d;
            err_idx_q      <= err_idx_d;
            err_seen_q     <= err_seen_d;
            sample_valid_q <= sample_valid_d;
            sample_idx_q   <= sample_idx_d;
            sample_val_q   <= sample_val_d;
        end
    end

`ifdef TT_CAPTURE_EN
    // Observed-output table: cleared on accept, one bit written per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obs_table <= '0;
        end else if (accept) begin
            obs_table <= '0;
        end else if (do_sample) begin
            obs_table[idx_q] <= dut_out;
        end
    end
`endif

    // Output decode; stim tracks idx, which is zero whenever the FSM is IDLE.
    always_comb begin
        stim         = idx_q;
        busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
        done         = (state_q == ST_DONE);
        pass         = done && (err_count_q == '0);
        sample_valid = sample_valid_q;
        sample_idx   = sample_idx_q;
        sample_val   = sample_val_q;
        err_count    = err_count_q;
        err_idx      = err_idx_q;
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed testbench for truth_table_sequencer with N_IN=2, HOLD_CYCLES=3.
// Honours TT_CAPTURE_EN by also checking obs_table.
module tb_truth_table_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dut_out;
    logic [3:0] exp_table;
    logic [1:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic       sample_valid;
    logic [1:0] sample_idx;
    logic       sample_val;
    logic [2:0] err_count;
    logic [1:0] err_idx;
`ifdef TT_CAPTURE_EN
    logic [3:0] obs_table;
`endif

    // 0: AND gate, 1: OR gate, 2: stuck at 0, 3: stuck at 1
    int gate_sel;

    int n_cmp;
    int n_fail;

    // Values collected by the sweep task
    int         n_samp;
    logic [3:0] samp_vals;
    logic [7:0] samp_idx_seq;
    logic [7:0] stim_seq;
    int         done_cyc;
    logic       busy0;
    logic       done0;
    logic [2:0] errc0;
    logic [1:0] erri0;

    truth_table_sequencer #(
        .N_IN        (2),
        .HOLD_CYCLES (3)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .dut_out      (dut_out),
        .exp_table    (exp_table),
        .stim         (stim),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .sample_valid (sample_valid),
        .sample_idx   (sample_idx),
        .sample_val   (sample_val),
        .err_count    (err_count),
        .err_idx      (err_idx)
`ifdef TT_CAPTURE_EN
        ,
        .obs_table    (obs_table)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate block being exercised.
    always_comb begin
        case (gate_sel)
            0:       dut_out = stim[0] & stim[1];
            1:       dut_out = stim[0] | stim[1];
            2:       dut_out = 1'b0;
            default: dut_out = 1'b1;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then follows the sweep for at most 40 cycles.
    // Cycle c counts edges after the accept edge; mid_start re-pulses start.
    task automatic sweep(input int mid_start);
        n_samp       = 0;
        samp_vals    = '0;
        samp_idx_seq = '0;
        stim_seq     = '0;
        done_cyc     = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy0 = busy;
        done0 = done;
        errc0 = err_count;
        erri0 = err_idx;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            start = (c - 1 == mid_start);
            tick();
            start = 1'b0;
            if (sample_valid) begin
                if (n_samp < 4) begin
                    samp_vals[n_samp]            = sample_val;
                    samp_idx_seq[n_samp*2 +: 2] = sample_idx;
                end
                n_samp++;
            end
            if (c < 16 && (c % 4) == 1) stim_seq[(c/4)*2 +: 2] = stim;
            if (done) done_cyc = c;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({stim, busy, done, pass, sample_valid, sample_idx, sample_val, err_count, err_idx}
            !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {stim, busy, done, pass, sample_valid, sample_idx, sample_val,
                      err_count, err_idx});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0 || stim !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b stim=%0d want busy=0 stim=0",
                     busy, stim);
        end
    endtask

    task automatic test_and_gate();
        gate_sel  = 0;
        exp_table = 4'b1000;
        sweep(-1);
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL and_busy_after_accept: got %b want 1", busy0);
        end
        n_cmp++;
        if (stim_seq !== 8'b11_10_01_00) begin
            n_fail++;
            $display("FAIL and_stim_steps: got %b want 11100100", stim_seq);
        end
        n_cmp++;
        if (n_samp !== 4) begin
            n_fail++;
            $display("FAIL and_sample_count: got %0d want 4", n_samp);
        end
        n_cmp++;
        if (samp_vals !== 4'b1000) begin
            n_fail++;
            $display("FAIL and_sample_vals: got %b want 1000", samp_vals);
        end
        n_cmp++;
        if (samp_idx_seq !== 8'b11_10_01_00) begin
            n_fail++;
            $display("FAIL and_sample_idx: got %b want 11100100", samp_idx_seq);
        end
        n_cmp++;
        if (done_cyc !== 16) begin
            n_fail++;
            $display("FAIL and_done_latency: got %0d want 16", done_cyc);
        end
        n_cmp++;
        if ({pass, err_count, err_idx} !== {1'b1, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL and_result: got pass=%b err=%0d idx=%0d want pass=1 err=0 idx=0",
                     pass, err_count, err_idx);
        end
`ifdef TT_CAPTURE_EN
        n_cmp++;
        if (obs_table !== 4'b1000) begin
            n_fail++;
            $display("FAIL and_obs_table: got %b want 1000", obs_table);
        end
`endif
        tick();
        tick();
        n_cmp++;
        if (done !== 1'b1 || stim !== 2'd3) begin
            n_fail++;
            $display("FAIL and_done_hold: got done=%b stim=%0d want done=1 stim=3", done, stim);
        end
    endtask

    task automatic test_or_gate();
        gate_sel  = 1;
        exp_table = 4'b1000;
        sweep(-1);
        n_cmp++;
        if ({pass, err_count, err_idx} !== {1'b0, 3'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL or_result: got pass=%b err=%0d idx=%0d want pass=0 err=2 idx=1",
                     pass, err_count, err_idx);
        end
        n_cmp++;
        if (samp_vals !== 4'b1110) begin
            n_fail++;
            $display("FAIL or_sample_vals: got %b want 1110", samp_vals);
        end
`ifdef TT_CAPTURE_EN
        n_cmp++;
        if (obs_table !== 4'b1110) begin
            n_fail++;
            $display("FAIL or_obs_table: got %b want 1110", obs_table);
        end
`endif
    endtask

    // Restart from DONE (after the failing OR sweep) with a start re-pulse at stim=2.
    task automatic test_back_to_back();
        gate_sel  = 0;
        exp_table = 4'b1000;
        sweep(9);
        n_cmp++;
        if ({done0, busy0, errc0, erri0} !== {1'b0, 1'b1, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL restart_clear: got done=%b busy=%b err=%0d idx=%0d want 0 1 0 0",
                     done0, busy0, errc0, erri0);
        end
        n_cmp++;
        if (done_cyc !== 16 || n_samp !== 4) begin
            n_fail++;
            $display("FAIL restart_mid_start_ignored: got done_cyc=%0d samples=%0d want 16 4",
                     done_cyc, n_samp);
        end
        n_cmp++;
        if ({pass, err_count, samp_vals} !== {1'b1, 3'd0, 4'b1000}) begin
            n_fail++;
            $display("FAIL restart_result: got pass=%b err=%0d vals=%b want 1 0 1000",
                     pass, err_count, samp_vals);
        end
    endtask

    task automatic test_stuck0();
        gate_sel  = 2;
        exp_table = 4'b1000;
        sweep(-1);
        n_cmp++;
        if ({pass, err_count, err_idx} !== {1'b0, 3'd1, 2'd3}) begin
            n_fail++;
            $display("FAIL stuck0_result: got pass=%b err=%0d idx=%0d want pass=0 err=1 idx=3",
                     pass, err_count, err_idx);
        end
`ifdef TT_CAPTURE_EN
        n_cmp++;
        if (obs_table !== 4'b0000) begin
            n_fail++;
            $display("FAIL stuck0_obs_table: got %b want 0000", obs_table);
        end
`endif
    endtask

    task automatic test_abort();
        gate_sel  = 3;
        exp_table = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        // Second SETTLE cycle of idx=1.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({stim, busy, done, pass} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got stim=%0d busy=%b done=%b pass=%b want all 0",
                     stim, busy, done, pass);
        end
        n_cmp++;
        if ({err_count, err_idx} !== {3'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL abort_partial: got err=%0d idx=%0d want err=1 idx=0",
                     err_count, err_idx);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        tick();
        n_cmp++;
        if ({busy, stim, err_count} !== {1'b0, 2'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL abort_beats_start: got busy=%b stim=%0d err=%0d want 0 0 1",
                     busy, stim, err_count);
        end
    endtask

    task automatic test_async_reset();
        int activity;
        gate_sel  = 3;
        exp_table = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({stim, busy, done, pass, sample_valid, sample_idx, sample_val, err_count, err_idx}
            !== 14'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b want all zero",
                     {stim, busy, done, pass, sample_valid, sample_idx, sample_val,
                      err_count, err_idx});
        end
`ifdef TT_CAPTURE_EN
        n_cmp++;
        if (obs_table !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_obs_table: got %b want 0000", obs_table);
        end
`endif
        #2;
        rst_n = 1'b1;
        activity = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || sample_valid || done || stim != 2'd0) activity++;
        end
        n_cmp++;
        if (activity !== 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %0d active cycles want 0", activity);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        gate_sel  = 0;
        exp_table = 4'b1000;
        test_reset();
        test_and_gate();
        test_or_gate();
        test_back_to_back();
        test_stuck0();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
